// File: rtl/multibank_bank_sequencer_pkg.sv
// Shared constants and helpers for the multi-bank bank sequencer.
package mb_pkg;

  localparam int unsigned SEL_HIGH   = 0;
  localparam int unsigned SEL_LOW    = 1;
  localparam int unsigned BUSY_CNT_W = 4;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/multibank_bank_sequencer_busy_timer.sv
// Per-bank recovery timer: loads on access, counts down to idle.
module bank_busy_timer
  import mb_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [BUSY_CNT_W-1:0] i_load_val,
  output logic                  o_busy
);

  logic [BUSY_CNT_W-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (i_load) begin
      cnt <= i_load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign o_busy = (cnt != '0);

endmodule

// File: rtl/multibank_bank_sequencer.sv
// Registered bank-select stage: address split, per-bank busy gating,
// one-cycle-latency bank enable/strobe outputs and a saturating stall counter.
module multibank_bank_sequencer
  import mb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned NUM_BANKS   = 4,
  parameter int unsigned SEL_MODE    = 0,
  parameter int unsigned BUSY_CYCLES = 2,
  parameter int unsigned STALL_CNT_W = 8
) (
  input  logic                                         i_clk,
  input  logic                                         i_rst,
  input  logic                                         i_valid,
  output logic                                         o_ready,
  input  logic [ADDR_WIDTH-1:0]                        i_addr,
  input  logic                                         i_wr,
  output logic                                         o_valid,
  output logic [NUM_BANKS-1:0]                         o_bank_en,
  output logic                                         o_bank_wr,
  output logic [ADDR_WIDTH-clog2(NUM_BANKS)-1:0]       o_local_addr,
  output logic [NUM_BANKS-1:0]                         o_busy,
  output logic [STALL_CNT_W-1:0]                       o_stall_cnt
);

  localparam int unsigned BANK_BITS = clog2(NUM_BANKS);
  localparam int unsigned LOCAL_W   = ADDR_WIDTH - BANK_BITS;
  localparam logic [BUSY_CNT_W-1:0] LOAD_VAL = BUSY_CNT_W'(BUSY_CYCLES);

  logic [BANK_BITS-1:0] idx;
  logic [LOCAL_W-1:0]   local_addr;
  logic [NUM_BANKS-1:0] onehot;
  logic [NUM_BANKS-1:0] busy;
  logic                 accept;

  if (SEL_MODE == SEL_HIGH) begin : g_sel_high
    assign idx        = i_addr[ADDR_WIDTH-1 -: BANK_BITS];
    assign local_addr = i_addr[LOCAL_W-1:0];
  end else begin : g_sel_low
    assign idx        = i_addr[BANK_BITS-1:0];
    assign local_addr = i_addr[ADDR_WIDTH-1:BANK_BITS];
  end

  // Bank index k maps to bit NUM_BANKS-1-k (bank 0 is the MSB).
  always_comb begin
    onehot = '0;
    for (int unsigned p = 0; p < NUM_BANKS; p++) begin
      onehot[p] = (idx == BANK_BITS'(NUM_BANKS - 1 - p));
    end
  end

  assign o_ready = !i_rst && ((busy & onehot) == '0);
  assign accept  = i_valid && o_ready;
  assign o_busy  = busy;

  for (genvar p = 0; p < NUM_BANKS; p++) begin : g_bank
    bank_busy_timer u_timer (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (accept && onehot[p]),
      .i_load_val (LOAD_VAL),
      .o_busy     (busy[p])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid      <= 1'b0;
      o_bank_en    <= '0;
      o_bank_wr    <= 1'b0;
      o_local_addr <= '0;
    end else begin
      o_valid   <= accept;
      o_bank_en <= accept ? onehot : '0;
      o_bank_wr <= accept && i_wr;
      if (accept) begin
        o_local_addr <= local_addr;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stall_cnt <= '0;
    end else if (i_valid && !o_ready && (o_stall_cnt != '1)) begin
      o_stall_cnt <= o_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_multibank_bank_sequencer.sv
// Self-checking bench: four configurations share one stimulus stream and are
// compared every cycle against a cycle-stamp model, plus literal spot checks.
module tb_multibank_bank_sequencer;

  localparam int NI = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [5:0] addr;
  logic       wr;

  int checks = 0;
  int errors = 0;

  // Per-instance configuration: sel mode, busy cycles, stall saturation value
  int sel_m [NI] = '{0, 1, 0, 0};
  int bc_m  [NI] = '{2, 2, 6, 0};
  int smax  [NI] = '{255, 255, 3, 255};

  logic       act_ready [NI];
  logic       act_valid [NI];
  logic [3:0] act_en    [NI];
  logic       act_wr    [NI];
  logic [3:0] act_local [NI];
  logic [3:0] act_busy  [NI];
  logic [7:0] act_stall [NI];
  logic [1:0] stall2;

  always #5 clk = ~clk;

  multibank_bank_sequencer #(.ADDR_WIDTH(6), .NUM_BANKS(4), .SEL_MODE(0),
                             .BUSY_CYCLES(2), .STALL_CNT_W(8)) u_d0 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(act_ready[0]),
    .i_addr(addr), .i_wr(wr), .o_valid(act_valid[0]), .o_bank_en(act_en[0]),
    .o_bank_wr(act_wr[0]), .o_local_addr(act_local[0]), .o_busy(act_busy[0]),
    .o_stall_cnt(act_stall[0]));

  multibank_bank_sequencer #(.ADDR_WIDTH(6), .NUM_BANKS(4), .SEL_MODE(1),
                             .BUSY_CYCLES(2), .STALL_CNT_W(8)) u_d1 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(act_ready[1]),
    .i_addr(addr), .i_wr(wr), .o_valid(act_valid[1]), .o_bank_en(act_en[1]),
    .o_bank_wr(act_wr[1]), .o_local_addr(act_local[1]), .o_busy(act_busy[1]),
    .o_stall_cnt(act_stall[1]));

  multibank_bank_sequencer #(.ADDR_WIDTH(6), .NUM_BANKS(4), .SEL_MODE(0),
                             .BUSY_CYCLES(6), .STALL_CNT_W(2)) u_d2 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(act_ready[2]),
    .i_addr(addr), .i_wr(wr), .o_valid(act_valid[2]), .o_bank_en(act_en[2]),
    .o_bank_wr(act_wr[2]), .o_local_addr(act_local[2]), .o_busy(act_busy[2]),
    .o_stall_cnt(stall2));

  assign act_stall[2] = {6'b0, stall2};

  multibank_bank_sequencer #(.ADDR_WIDTH(6), .NUM_BANKS(4), .SEL_MODE(0),
                             .BUSY_CYCLES(0), .STALL_CNT_W(8)) u_d3 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(act_ready[3]),
    .i_addr(addr), .i_wr(wr), .o_valid(act_valid[3]), .o_bank_en(act_en[3]),
    .o_bank_wr(act_wr[3]), .o_local_addr(act_local[3]), .o_busy(act_busy[3]),
    .o_stall_cnt(act_stall[3]));

  task automatic chk(input string nm, input int inst,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[d%0d] at %0t: got %0h expected %0h", nm, inst, $time, act, exp);
    end
  endtask

  function automatic int idx_of(input int inst, input logic [5:0] a);
    return (sel_m[inst] == 0) ? int'(a[5:4]) : int'(a[1:0]);
  endfunction

  function automatic logic [3:0] local_of(input int inst, input logic [5:0] a);
    return (sel_m[inst] == 0) ? a[3:0] : a[5:2];
  endfunction

  // Model: each bank records the edge number from which it may accept again.
  int         e = 0;
  int         free_at   [NI][4];
  int         exp_stall [NI];
  logic       exp_valid [NI];
  logic [3:0] exp_en    [NI];
  logic       exp_wr    [NI];
  logic [3:0] exp_local [NI];

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        for (int b = 0; b < 4; b++) free_at[i][b] = 0;
        exp_valid[i] = 1'b0;
        exp_en[i]    = 4'b0;
        exp_wr[i]    = 1'b0;
        exp_local[i] = 4'b0;
        exp_stall[i] = 0;
      end else begin
        int  k;
        bit  rdy;
        bit  acc;
        k   = idx_of(i, addr);
        rdy = (e >= free_at[i][k]);
        acc = valid && rdy;
        if (valid && !rdy && exp_stall[i] < smax[i]) exp_stall[i]++;
        exp_valid[i] = acc;
        exp_en[i]    = acc ? (4'b1000 >> k) : 4'b0;
        exp_wr[i]    = acc && wr;
        if (acc) begin
          exp_local[i]    = local_of(i, addr);
          free_at[i][k]   = e + bc_m[i] + 1;
        end
      end
    end
    e++;
    #2;
    for (int i = 0; i < NI; i++) begin
      logic [3:0] eb;
      eb = 4'b0;
      for (int b = 0; b < 4; b++) if (e < free_at[i][b]) eb = eb | (4'b1000 >> b);
      chk("ready", i, 32'(act_ready[i]), 32'(!rst && (e >= free_at[i][idx_of(i, addr)])));
      chk("valid", i, 32'(act_valid[i]), 32'(exp_valid[i]));
      chk("bank_en", i, 32'(act_en[i]), 32'(exp_en[i]));
      chk("bank_wr", i, 32'(act_wr[i]), 32'(exp_wr[i]));
      chk("busy", i, 32'(act_busy[i]), 32'(eb));
      chk("stall_cnt", i, 32'(act_stall[i]), 32'(exp_stall[i]));
      if (exp_valid[i]) chk("local_addr", i, 32'(act_local[i]), 32'(exp_local[i]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic drive(input logic v, input logic [5:0] a, input logic w);
    valid = v;
    addr  = a;
    wr    = w;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 6'h00, 1'b0);
    tick();
    tick();
    chk("L_rst_valid", 0, 32'(act_valid[0]), 0);
    chk("L_rst_en", 0, 32'(act_en[0]), 0);
    chk("L_rst_local", 0, 32'(act_local[0]), 0);
    chk("L_rst_stall", 0, 32'(act_stall[0]), 0);
    rst = 1'b0;

    // Single write to bank 2
    drive(1'b1, 6'b10_1011, 1'b1);
    tick();
    chk("L_w_valid", 0, 32'(act_valid[0]), 1);
    chk("L_w_en", 0, 32'(act_en[0]), 32'h2);
    chk("L_w_local", 0, 32'(act_local[0]), 32'hB);
    chk("L_w_wr", 0, 32'(act_wr[0]), 1);
    chk("L_w_busy1", 0, 32'(act_busy[0]), 32'h2);
    drive(1'b0, 6'b10_1011, 1'b0);
    tick();
    chk("L_w_busy2", 0, 32'(act_busy[0]), 32'h2);
    chk("L_w_wr_low", 0, 32'(act_wr[0]), 0);
    tick();
    chk("L_w_busy3", 0, 32'(act_busy[0]), 0);

    // Back-to-back across banks
    for (int n = 0; n < 4; n++) begin
      logic [5:0] a;
      logic [3:0] en;
      a  = 6'(n * 16);
      en = 4'b1000 >> n;
      drive(1'b1, a, 1'b0);
      tick();
      chk("L_b2b_valid", 0, 32'(act_valid[0]), 1);
      chk("L_b2b_en", 0, 32'(act_en[0]), 32'(en));
    end
    chk("L_b2b_stall", 0, 32'(act_stall[0]), 0);
    drive(1'b0, 6'h00, 1'b0);
    for (int n = 0; n < 8; n++) tick();

    // Same-bank back-to-back: second accepted three cycles after the first
    drive(1'b1, 6'h05, 1'b0);
    tick();
    chk("L_sb_first", 0, 32'(act_valid[0]), 1);
    tick();
    chk("L_sb_rdy1", 0, 32'(act_ready[0]), 0);
    chk("L_sb_stall1", 0, 32'(act_stall[0]), 1);
    tick();
    chk("L_sb_rdy2", 0, 32'(act_ready[0]), 1);
    chk("L_sb_stall2", 0, 32'(act_stall[0]), 2);
    tick();
    chk("L_sb_second", 0, 32'(act_valid[0]), 1);
    chk("L_sb_en", 0, 32'(act_en[0]), 32'h8);
    drive(1'b0, 6'h00, 1'b0);
    for (int n = 0; n < 8; n++) tick();

    // Interleaved mapping
    drive(1'b1, 6'b1101_10, 1'b0);
    tick();
    chk("L_il_valid", 1, 32'(act_valid[1]), 1);
    chk("L_il_en", 1, 32'(act_en[1]), 32'h2);
    chk("L_il_local", 1, 32'(act_local[1]), 32'hD);
    drive(1'b0, 6'h00, 1'b0);
    for (int n = 0; n < 8; n++) tick();

    // Reset right after an acceptance
    drive(1'b1, 6'h2A, 1'b1);
    tick();
    chk("L_mr_acc", 0, 32'(act_valid[0]), 1);
    rst = 1'b1;
    tick();
    chk("L_mr_valid", 0, 32'(act_valid[0]), 0);
    chk("L_mr_busy", 0, 32'(act_busy[0]), 0);
    chk("L_mr_stall", 0, 32'(act_stall[0]), 0);
    chk("L_mr_wr", 0, 32'(act_wr[0]), 0);
    rst = 1'b0;
    #1;
    chk("L_mr_ready", 0, 32'(act_ready[0]), 1);
    tick();
    chk("L_mr_post", 0, 32'(act_valid[0]), 1);
    chk("L_mr_en", 0, 32'(act_en[0]), 32'h2);

    // Hold the same bank: 2-bit stall counter saturates, zero-busy config never stalls
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("L_z_ready", 3, 32'(act_ready[3]), 1);
      chk("L_z_valid", 3, 32'(act_valid[3]), 1);
    end
    chk("L_sat_stall", 2, 32'(act_stall[2]), 3);
    chk("L_sat_busy", 2, 32'(act_busy[2]), 32'h2);
    chk("L_z_stall", 3, 32'(act_stall[3]), 0);
    drive(1'b0, 6'h00, 1'b0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
